// File: rtl/sgmii_link_ctrl_if.sv
// Signal bundle between the SGMII link sequencer and the PCS/PMA core / MAC side.
interface sgmii_link_ctrl_if;
  logic        link_restart;
  logic        resetdone;
  logic        mmcm_locked_out;
  logic [15:0] status_vector;
  logic        pcs_reset;
  logic        an_restart_config;
  logic        link_up;
  logic        mac_tx_enable;
  logic [1:0]  link_speed;
  logic        fail;
  logic [2:0]  retry_cnt;
  logic [2:0]  state;

  // Sequencer side: observes the core, drives reset/AN and link status.
  modport master (
    input  link_restart,
    input  resetdone,
    input  mmcm_locked_out,
    input  status_vector,
    output pcs_reset,
    output an_restart_config,
    output link_up,
    output mac_tx_enable,
    output link_speed,
    output fail,
    output retry_cnt,
    output state
  );

  // Environment side: core status and software control.
  modport slave (
    output link_restart,
    output resetdone,
    output mmcm_locked_out,
    output status_vector,
    input  pcs_reset,
    input  an_restart_config,
    input  link_up,
    input  mac_tx_enable,
    input  link_speed,
    input  fail,
    input  retry_cnt,
    input  state
  );
endinterface

// File: rtl/sgmii_link_ctrl.sv
// SGMII bring-up/supervision sequencer: core reset, AN restart, debounced
// link detection, timeout retries and MAC transmit gating. Runs on the
// free-running clock so it keeps supervising while GT clocks are absent.
module sgmii_link_ctrl #(
  parameter int unsigned RST_HOLD_CYCLES      = 200,
  parameter int unsigned LOCK_TIMEOUT_CYCLES  = 2000000,
  parameter int unsigned AN_TIMEOUT_CYCLES    = 20000000,
  parameter int unsigned LINK_DEBOUNCE_CYCLES = 1000,
  parameter int unsigned AN_PULSE_CYCLES      = 4,
  parameter int unsigned MAX_RETRY            = 7
) (
  input  logic              independent_clock_bufg,
  input  logic              sys_rst,
  sgmii_link_ctrl_if.master bus
);

  localparam int unsigned MAX_TO  = (LOCK_TIMEOUT_CYCLES > AN_TIMEOUT_CYCLES) ?
                                    LOCK_TIMEOUT_CYCLES : AN_TIMEOUT_CYCLES;
  localparam int unsigned MAX_RA  = (RST_HOLD_CYCLES > AN_PULSE_CYCLES) ?
                                    RST_HOLD_CYCLES : AN_PULSE_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_TO > MAX_RA) ? MAX_TO : MAX_RA;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned DEB_W   = $clog2(LINK_DEBOUNCE_CYCLES + 1);
  localparam int unsigned RETRY_W = 3;
  localparam int unsigned SYNC_W  = 6;

  localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LOCK_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   AN_LAST   = CNT_W'(AN_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_SAT   = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0]   AN_PULSE  = CNT_W'(AN_PULSE_CYCLES);
  localparam logic [DEB_W-1:0]   DEB_LAST  = DEB_W'(LINK_DEBOUNCE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    WAIT_LOCK  = 3'd1,
    WAIT_AN    = 3'd2,
    LINK_UP    = 3'd3,
    RETRY      = 3'd4,
    FAILED     = 3'd5
  } state_e;

  logic clk;
  assign clk = independent_clock_bufg;

  // Only the link, sync and speed bits of the status vector are consumed.
  logic unused_status;
  assign unused_status = ^{bus.status_vector[15:12], bus.status_vector[9:2]};

  // ---------------------------------------------------------------------------
  // Input synchronisers: {speed[1:0], link_sync, link_status, locked, resetdone}
  // ---------------------------------------------------------------------------
  logic [SYNC_W-1:0] sync_in;
  logic [SYNC_W-1:0] meta_q;
  logic [SYNC_W-1:0] sync_q;

  assign sync_in = {bus.status_vector[11:10], bus.status_vector[1],
                    bus.status_vector[0], bus.mmcm_locked_out, bus.resetdone};

  // Two-flop synchroniser chain for all asynchronous core status inputs.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= sync_in;
      sync_q <= meta_q;
    end
  end

  logic       rd_s;
  logic       lock_s;
  logic       lstat_s;
  logic       lsync_s;
  logic [1:0] speed_s;
  logic       link_ok;

  assign rd_s    = sync_q[0];
  assign lock_s  = sync_q[1];
  assign lstat_s = sync_q[2];
  assign lsync_s = sync_q[3];
  assign speed_s = sync_q[5:4];
  assign link_ok = lstat_s & lsync_s & lock_s & rd_s;

  // ---------------------------------------------------------------------------
  // State, counters and registered outputs
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DEB_W-1:0]   deb_q, deb_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [1:0]         speed_q, speed_d;
  logic               pcs_reset_q, pcs_reset_d;
  logic               an_q, an_d;
  logic               link_up_q, link_up_d;
  logic               mac_en_q, mac_en_d;
  logic               fail_q, fail_d;

  // State register and output flops; sys_rst dominates everything.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q     <= RESET_HOLD;
      cnt_q       <= '0;
      deb_q       <= '0;
      retry_q     <= '0;
      speed_q     <= '0;
      pcs_reset_q <= 1'b1;
      an_q        <= 1'b0;
      link_up_q   <= 1'b0;
      mac_en_q    <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      deb_q       <= deb_d;
      retry_q     <= retry_d;
      speed_q     <= speed_d;
      pcs_reset_q <= pcs_reset_d;
      an_q        <= an_d;
      link_up_q   <= link_up_d;
      mac_en_q    <= mac_en_d;
      fail_q      <= fail_d;
    end
  end

  logic             deb_done;
  logic             enter;
  logic [CNT_W-1:0] cnt_inc;

  // Next-state, counters and next-output values.
  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    speed_d     = speed_q;
    deb_d       = '0;
    deb_done    = 1'b0;
    enter       = 1'b0;
    cnt_inc     = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
    cnt_d       = cnt_inc;
    pcs_reset_d = 1'b0;
    an_d        = 1'b0;
    link_up_d   = 1'b0;
    mac_en_d    = 1'b0;
    fail_d      = 1'b0;

    case (state_q)
      RESET_HOLD: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (rd_s && lock_s)          state_d = WAIT_AN;
        else if (cnt_q == LOCK_LAST) state_d = RETRY;
      end
      WAIT_AN: begin
        // Debounce completion takes precedence over the AN timeout.
        deb_d    = link_ok ? deb_q + DEB_W'(1) : '0;
        deb_done = link_ok && (deb_q == DEB_LAST);
        if (deb_done) begin
          speed_d = speed_s;
          state_d = (speed_s == 2'b10) ? LINK_UP : RETRY;
        end else if (cnt_q == AN_LAST) begin
          state_d = RETRY;
        end
      end
      LINK_UP: begin
        // Link loss restarts bring-up without consuming a retry.
        if (!link_ok) begin
          state_d = RESET_HOLD;
          retry_d = '0;
        end
      end
      RETRY: begin
        if (retry_q == RETRY_MAX) begin
          state_d = FAILED;
        end else begin
          retry_d = retry_q + RETRY_W'(1);
          state_d = RESET_HOLD;
        end
      end
      FAILED: begin
        state_d = FAILED;
      end
      default: begin
        state_d = RESET_HOLD;
      end
    endcase

    if (bus.link_restart) begin
      state_d = RESET_HOLD;
      retry_d = '0;
    end

    // Every state entry (or software restart) clears the shared counters.
    enter = bus.link_restart || (state_d != state_q);
    if (enter) begin
      cnt_d = '0;
      deb_d = '0;
    end

    pcs_reset_d = (state_d == RESET_HOLD) || (state_d == RETRY) || (state_d == FAILED);
    an_d        = (state_d == WAIT_AN) && (cnt_d < AN_PULSE);
    link_up_d   = (state_d == LINK_UP);
    mac_en_d    = (state_d == LINK_UP);
    fail_d      = (state_d == FAILED);
  end

  assign bus.pcs_reset         = pcs_reset_q;
  assign bus.an_restart_config = an_q;
  assign bus.link_up           = link_up_q;
  assign bus.mac_tx_enable     = mac_en_q;
  assign bus.link_speed        = speed_q;
  assign bus.fail              = fail_q;
  assign bus.retry_cnt         = retry_q;
  assign bus.state             = state_q;

endmodule

// File: tb/tb_sgmii_link_ctrl.sv
// Self-checking bench for sgmii_link_ctrl: directed scenarios plus a
// scoreboard of expected link-up events (cycle, speed, retry count).
module tb_sgmii_link_ctrl;

  logic clk = 1'b0;
  logic sys_rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic prev_up = 1'b0;

  typedef struct {
    int         at_cyc;
    logic [1:0] speed;
    logic [2:0] retry;
  } exp_t;

  exp_t exp_q[$];

  sgmii_link_ctrl_if bus();

  sgmii_link_ctrl #(
    .RST_HOLD_CYCLES      (4),
    .LOCK_TIMEOUT_CYCLES  (50),
    .AN_TIMEOUT_CYCLES    (200),
    .LINK_DEBOUNCE_CYCLES (8),
    .AN_PULSE_CYCLES      (4),
    .MAX_RETRY            (2)
  ) u_dut (
    .independent_clock_bufg (clk),
    .sys_rst                (sys_rst),
    .bus                    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Advance to the next falling edge and score any link_up rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (bus.link_up === 1'b1 && prev_up !== 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL link_up_unexpected: link_up rose at cycle %0d, required no rise", cyc);
      end else begin
        e = exp_q.pop_front();
        if (cyc != e.at_cyc || bus.link_speed !== e.speed || bus.retry_cnt !== e.retry) begin
          n_fail++;
          $display("FAIL link_up_event: got cycle %0d speed %b retry %0d, required cycle %0d speed %b retry %0d",
                   cyc, bus.link_speed, bus.retry_cnt, e.at_cyc, e.speed, e.retry);
        end
      end
    end
    prev_up = bus.link_up;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int k = 0;
    while (bus.state !== s && k < budget) begin
      tick();
      k++;
    end
    n_tests++;
    if (bus.state !== s) begin
      n_fail++;
      $display("FAIL %s: state %0d after %0d cycles, required %0d", tag, bus.state, budget, s);
    end
  endtask

  task automatic wait_retry(input logic [2:0] r, input int budget, input string tag);
    int k = 0;
    while (bus.retry_cnt !== r && k < budget) begin
      tick();
      k++;
    end
    n_tests++;
    if (bus.retry_cnt !== r) begin
      n_fail++;
      $display("FAIL %s: retry_cnt %0d after %0d cycles, required %0d", tag, bus.retry_cnt, budget, r);
    end
  endtask

  task automatic wait_up(input int budget, input string tag);
    int k = 0;
    while (bus.link_up !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    n_tests++;
    if (bus.link_up !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: link_up %b after %0d cycles, required 1", tag, bus.link_up, budget);
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (bus.state !== 3'd0 || bus.pcs_reset !== 1'b1 || bus.an_restart_config !== 1'b0 ||
        bus.link_up !== 1'b0 || bus.mac_tx_enable !== 1'b0 || bus.link_speed !== 2'b00 ||
        bus.fail !== 1'b0 || bus.retry_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_values: state %0d pcs %b an %b up %b mac %b spd %b fail %b retry %0d, required 0 1 0 0 0 00 0 0",
               bus.state, bus.pcs_reset, bus.an_restart_config, bus.link_up, bus.mac_tx_enable,
               bus.link_speed, bus.fail, bus.retry_cnt);
    end
  endtask

  task automatic test_nominal();
    int pcs_hi = 0;
    int an_hi  = 0;
    sys_rst = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      if (k == 10) begin
        bus.resetdone       = 1'b1;
        bus.mmcm_locked_out = 1'b1;
      end
      if (k == 20) begin
        bus.status_vector = 16'h0803;
        exp_q.push_back('{cyc + 10, 2'b10, 3'd0});
      end
      if (bus.pcs_reset === 1'b1) pcs_hi++;
      if (bus.an_restart_config === 1'b1) an_hi++;
      tick();
    end
    n_tests++;
    if (pcs_hi != 4) begin
      n_fail++;
      $display("FAIL nominal_pcs_reset_width: %0d cycles, required 4", pcs_hi);
    end
    n_tests++;
    if (an_hi != 4) begin
      n_fail++;
      $display("FAIL nominal_an_pulse_width: %0d cycles, required 4", an_hi);
    end
    n_tests++;
    if (bus.link_up !== 1'b1 || bus.mac_tx_enable !== 1'b1 || bus.link_speed !== 2'b10 || bus.state !== 3'd3) begin
      n_fail++;
      $display("FAIL nominal_link: up %b mac %b spd %b state %0d, required 1 1 10 3",
               bus.link_up, bus.mac_tx_enable, bus.link_speed, bus.state);
    end
  endtask

  task automatic test_debounce_glitch();
    int n;
    bus.status_vector = 16'h0000;
    wait_state(3'd2, 40, "glitch_reach_wait_an");
    n = cyc;
    bus.status_vector = 16'h0803;
    repeat (4) tick();
    bus.status_vector = 16'h0802;
    tick();
    bus.status_vector = 16'h0803;
    exp_q.push_back('{cyc + 10, 2'b10, 3'd0});
    while (cyc < n + 10) tick();
    n_tests++;
    if (bus.link_up !== 1'b0 || bus.state !== 3'd2) begin
      n_fail++;
      $display("FAIL glitch_no_early_link: up %b state %0d, required 0 2", bus.link_up, bus.state);
    end
    wait_up(20, "glitch_link_up");
    n_tests++;
    if (bus.retry_cnt !== 3'd0 || bus.state !== 3'd3) begin
      n_fail++;
      $display("FAIL glitch_no_retry: retry %0d state %0d, required 0 3", bus.retry_cnt, bus.state);
    end
  endtask

  task automatic test_wrong_speed();
    int m;
    bus.status_vector = 16'h0000;
    wait_state(3'd2, 40, "speed_reach_wait_an");
    m = cyc;
    bus.status_vector = 16'h0403;
    while (cyc < m + 10) tick();
    n_tests++;
    if (bus.state !== 3'd4 || bus.link_speed !== 2'b01 || bus.link_up !== 1'b0) begin
      n_fail++;
      $display("FAIL speed_retry_entry: state %0d spd %b up %b, required 4 01 0",
               bus.state, bus.link_speed, bus.link_up);
    end
    bus.status_vector = 16'h0000;
    tick();
    n_tests++;
    if (bus.retry_cnt !== 3'd1 || bus.state !== 3'd0 || bus.mac_tx_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL speed_retry_count: retry %0d state %0d mac %b, required 1 0 0",
               bus.retry_cnt, bus.state, bus.mac_tx_enable);
    end
    wait_state(3'd2, 40, "speed_rebringup_wait_an");
    bus.status_vector = 16'h0803;
    exp_q.push_back('{cyc + 10, 2'b10, 3'd1});
    wait_up(20, "speed_rebringup_link_up");
  endtask

  task automatic test_link_loss();
    int m;
    m = cyc;
    bus.status_vector = 16'h0801;
    while (cyc < m + 2) tick();
    n_tests++;
    if (bus.link_up !== 1'b1) begin
      n_fail++;
      $display("FAIL loss_sync_delay: up %b two cycles after drop, required 1", bus.link_up);
    end
    tick();
    n_tests++;
    if (bus.link_up !== 1'b0 || bus.mac_tx_enable !== 1'b0 || bus.retry_cnt !== 3'd0 || bus.state !== 3'd0) begin
      n_fail++;
      $display("FAIL loss_teardown: up %b mac %b retry %0d state %0d, required 0 0 0 0",
               bus.link_up, bus.mac_tx_enable, bus.retry_cnt, bus.state);
    end
    wait_state(3'd2, 40, "loss_reach_wait_an");
    bus.status_vector = 16'h0803;
    exp_q.push_back('{cyc + 10, 2'b10, 3'd0});
    wait_up(20, "loss_rebringup_link_up");
  endtask

  task automatic test_priority();
    int r;
    int hi = 0;
    sys_rst          = 1'b1;
    bus.link_restart = 1'b1;
    tick();
    n_tests++;
    if (bus.state !== 3'd0 || bus.pcs_reset !== 1'b1 || bus.an_restart_config !== 1'b0 ||
        bus.link_up !== 1'b0 || bus.mac_tx_enable !== 1'b0 || bus.link_speed !== 2'b00 ||
        bus.fail !== 1'b0 || bus.retry_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL priority_reset: state %0d pcs %b an %b up %b mac %b spd %b fail %b retry %0d, required 0 1 0 0 0 00 0 0",
               bus.state, bus.pcs_reset, bus.an_restart_config, bus.link_up, bus.mac_tx_enable,
               bus.link_speed, bus.fail, bus.retry_cnt);
    end
    sys_rst          = 1'b0;
    bus.link_restart = 1'b0;
    wait_state(3'd2, 40, "priority_reach_wait_an");
    tick();
    tick();
    r = cyc;
    bus.link_restart = 1'b1;
    exp_q.push_back('{r + 14, 2'b10, 3'd0});
    tick();
    bus.link_restart = 1'b0;
    n_tests++;
    if (bus.state !== 3'd0 || bus.pcs_reset !== 1'b1 || bus.an_restart_config !== 1'b0 || bus.retry_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL restart_mid_an: state %0d pcs %b an %b retry %0d, required 0 1 0 0",
               bus.state, bus.pcs_reset, bus.an_restart_config, bus.retry_cnt);
    end
    while (bus.pcs_reset === 1'b1 && hi < 10) begin
      hi++;
      tick();
    end
    n_tests++;
    if (hi != 4) begin
      n_fail++;
      $display("FAIL restart_hold_width: pcs_reset %0d cycles, required 4", hi);
    end
    wait_up(20, "restart_link_up");
  endtask

  task automatic test_lock_timeout();
    bus.resetdone = 1'b0;
    wait_retry(3'd1, 150, "timeout_retry1");
    n_tests++;
    if (bus.state !== 3'd0 || bus.pcs_reset !== 1'b1 || bus.fail !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_retry1_state: state %0d pcs %b fail %b, required 0 1 0",
               bus.state, bus.pcs_reset, bus.fail);
    end
    wait_retry(3'd2, 150, "timeout_retry2");
    wait_state(3'd5, 150, "timeout_failed");
    n_tests++;
    if (bus.fail !== 1'b1 || bus.pcs_reset !== 1'b1 || bus.retry_cnt !== 3'd2 || bus.link_up !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_failed_outputs: fail %b pcs %b retry %0d up %b, required 1 1 2 0",
               bus.fail, bus.pcs_reset, bus.retry_cnt, bus.link_up);
    end
    repeat (20) tick();
    n_tests++;
    if (bus.state !== 3'd5 || bus.pcs_reset !== 1'b1 || bus.retry_cnt !== 3'd2) begin
      n_fail++;
      $display("FAIL timeout_failed_sticky: state %0d pcs %b retry %0d, required 5 1 2",
               bus.state, bus.pcs_reset, bus.retry_cnt);
    end
    bus.link_restart = 1'b1;
    tick();
    bus.link_restart = 1'b0;
    n_tests++;
    if (bus.fail !== 1'b0 || bus.retry_cnt !== 3'd0 || bus.state !== 3'd0) begin
      n_fail++;
      $display("FAIL timeout_restart_clear: fail %b retry %0d state %0d, required 0 0 0",
               bus.fail, bus.retry_cnt, bus.state);
    end
  endtask

  initial begin
    sys_rst             = 1'b1;
    bus.link_restart    = 1'b0;
    bus.resetdone       = 1'b0;
    bus.mmcm_locked_out = 1'b0;
    bus.status_vector   = 16'h0000;

    test_reset();
    test_nominal();
    test_debounce_glitch();
    test_wrong_speed();
    test_link_loss();
    test_priority();
    test_lock_timeout();

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expected link-up events never seen, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sgmii_link_ctrl.md
Name: sgmii_link_ctrl

Overview:
- Bring-up and supervision sequencer for the SGMII PCS/PMA wrapper.
- Drives the core reset and the auto-negotiation restart.
- Watches resetdone, mmcm_locked_out and status_vector, and retries bring-up on timeout or link loss.
- Gates the MAC transmit path: mac_tx_enable is high only while a stable 1000M link is up.
- Runs on the 200 MHz free-running clock, so it keeps working while the GT clocks are absent.

Parameters:
- RST_HOLD_CYCLES, 200: cycles pcs_reset is held high per attempt (1 us).
- LOCK_TIMEOUT_CYCLES, 2000000: max cycles to wait for resetdone and mmcm_locked_out (10 ms).
- AN_TIMEOUT_CYCLES, 20000000: max cycles to wait for a debounced link after AN restart (100 ms).
- LINK_DEBOUNCE_CYCLES, 1000: consecutive cycles link conditions must hold before link_up.
- AN_PULSE_CYCLES, 4: width of the an_restart_config pulse.
- MAX_RETRY, 7: timeout-retry limit before the FAILED state.

Ports:
- independent_clock_bufg  in  1  200 MHz free-running clock; the only clock.
- sys_rst  in  1  synchronous, active-high reset.
- link_restart  in  1  one-cycle software request to restart bring-up.
- resetdone  in  1  core reset-done; asynchronous, synchronised internally.
- mmcm_locked_out  in  1  core MMCM lock; asynchronous, synchronised internally.
- status_vector  in  16  core status; bit0 link_status, bit1 link_sync, bits[11:10] speed; asynchronous.
- pcs_reset  out  1  drives the core reset.
- an_restart_config  out  1  AN restart pulse to the core.
- link_up  out  1  link is stable at 1000M.
- mac_tx_enable  out  1  permits MAC frame transmission.
- link_speed  out  2  speed latched at link-up.
- fail  out  1  retry budget exhausted.
- retry_cnt  out  3  timeout retries consumed.
- state  out  3  current FSM state, for debug.

Behaviour:
- Input synchronisers: 2-flop synchronisers on resetdone, mmcm_locked_out, status_vector[0], [1] and [11:10]. An input change is visible to the FSM 2 cycles later. The synchronised speed is used only once debounce completes.
- Reset values (sys_rst high): state=RESET_HOLD(0), pcs_reset=1, an_restart_config=0, link_up=0, mac_tx_enable=0, link_speed=0, fail=0, retry_cnt=0. All counters are 0.
- Priority: sys_rst > link_restart > FSM transitions.
- link_restart in any state: go to RESET_HOLD, clear retry_cnt and fail, clear all counters.
- One shared cycle counter, cleared on every state entry.
- RESET_HOLD(0):
  - pcs_reset=1.
  - After RST_HOLD_CYCLES cycles, go to WAIT_LOCK.
- WAIT_LOCK(1):
  - pcs_reset=0.
  - When synced resetdone & mmcm_locked are both 1, go to WAIT_AN.
  - When the counter reaches LOCK_TIMEOUT_CYCLES, go to RETRY.
- WAIT_AN(2):
  - an_restart_config=1 for the first AN_PULSE_CYCLES cycles, then 0.
  - Debounce counter increments while link_status & link_sync & lock & resetdone all hold; it clears to 0 on any drop.
  - At LINK_DEBOUNCE_CYCLES: latch link_speed, then go to LINK_UP if speed==2'b10, else go to RETRY.
  - When the counter reaches AN_TIMEOUT_CYCLES, go to RETRY.
  - If debounce completion and timeout occur in the same cycle, completion wins.
- LINK_UP(3):
  - link_up=1, mac_tx_enable=1.
  - Any synced drop of link_status, link_sync, mmcm_locked or resetdone: next cycle link_up=0 and mac_tx_enable=0, retry_cnt cleared, go to RESET_HOLD.
  - A link loss is not counted as a retry.
- RETRY(4):
  - Lasts one cycle; pcs_reset=1.
  - If retry_cnt==MAX_RETRY, go to FAILED. Otherwise increment retry_cnt and go to RESET_HOLD.
  - retry_cnt never wraps.
- FAILED(5):
  - pcs_reset=1, fail=1.
  - Left only via sys_rst or link_restart.
- link_up and mac_tx_enable are 0 in every state except LINK_UP. link_speed holds its last latched value until the next latch or reset.
- All outputs are registered.

Test Plan:
(Bench parameters: RST_HOLD=4, LOCK_TIMEOUT=50, AN_TIMEOUT=200, DEBOUNCE=8, AN_PULSE=4, MAX_RETRY=2.)
1. Nominal bring-up: release sys_rst; assert resetdone/locked at cycle 10; status_vector=16'h0803 at cycle 20. Required: pcs_reset high exactly 4 cycles, an_restart_config high 4 cycles, link_up=mac_tx_enable=1 after 8 stable cycles + 2 sync, link_speed=2'b10.
2. Debounce glitch: link_status drops for 1 cycle mid-debounce. Required: debounce restarts from 0; link_up is delayed accordingly with no retry.
3. Lock timeout: resetdone is never asserted. Required: retry_cnt steps 1,2; the third timeout gives fail=1, state=5, pcs_reset=1 held. A later link_restart pulse gives fail=0, retry_cnt=0, state=0.
4. Link loss: from LINK_UP drop link_sync. Required: link_up=mac_tx_enable=0 within 3 cycles, retry_cnt=0, new bring-up succeeds.
5. Wrong speed: status_vector=16'h0403 (100M). Required: RETRY after debounce, retry_cnt=1, link_up never asserts.
6. Priority: sys_rst and link_restart asserted together in LINK_UP. Required: all outputs take reset values the next cycle; link_restart alone mid-WAIT_AN gives state=0 and counters cleared.
